// File: rtl/tt_lut_pkg.sv
// ============================================================================
// Module : tt_lut_pkg
// Brief  : Shared types and constants for the truth-table LUT engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tt_lut_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam logic [7:0] TT_RESET_DEFAULT = 8'h12;
    localparam int         N_IN_MAX         = 6;

endpackage

`default_nettype wire

// File: rtl/tt_lut_loader.sv
// ============================================================================
// Module : tt_lut_loader
// Brief  : Serial truth-table loader with shadow register and atomic commit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_lut_loader
    import tt_lut_pkg::*;
#(
    parameter int                N_IN     = 3,
    parameter logic [2**N_IN-1:0] TT_RESET = (2**N_IN)'(TT_RESET_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid_i,
    input  logic                 cfg_bit_i,
    output logic [2**N_IN-1:0]   table_o,
    output logic                 cfg_done_o
);

    localparam int TBL_W = 2**N_IN;

    logic [TBL_W-1:0] shadow_q, shadow_d;
    logic [TBL_W-1:0] table_q, table_d;
    logic [N_IN-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;

    // Bits shift in from the top so that the first bit lands at index 0
    // once the whole table has arrived.
    always_comb begin
        shadow_d = shadow_q;
        table_d  = table_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (cfg_valid_i) begin
            shadow_d = {cfg_bit_i, shadow_q[TBL_W-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                table_d = shadow_d;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= TT_RESET;
            table_q  <= TT_RESET;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            table_q  <= table_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign table_o    = table_q;
    assign cfg_done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/tt_lut_engine.sv
// ============================================================================
// Module : tt_lut_engine
// Brief  : Reconfigurable truth-table evaluator with optional auto-sweep
//          (sweep present when macro TT_LUT_SWEEP_EN is defined).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_lut_engine
    import tt_lut_pkg::*;
#(
    parameter int                 N_IN     = 3,
    parameter logic [2**N_IN-1:0] TT_RESET = (2**N_IN)'(TT_RESET_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic            out_y,
    output logic [N_IN-1:0] out_idx,
    input  logic            out_ready
`ifdef TT_LUT_SWEEP_EN
    ,
    input  logic            sweep_start,
    output logic            sweep_busy,
    output logic [N_IN:0]   ones_cnt
`endif
);

    localparam int TBL_W = 2**N_IN;

    logic [TBL_W-1:0] table_w;
    logic             slot_w;
    logic             accept_w;
    logic             out_valid_q, out_valid_d;
    logic             out_y_q, out_y_d;
    logic [N_IN-1:0]  out_idx_q, out_idx_d;

    tt_lut_loader #(
        .N_IN     (N_IN),
        .TT_RESET (TT_RESET)
    ) u_loader (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid_i (cfg_valid),
        .cfg_bit_i   (cfg_bit),
        .table_o     (table_w),
        .cfg_done_o  (cfg_done)
    );

    assign cfg_ready = ~reset;
    assign slot_w    = ~out_valid_q | out_ready;
    assign accept_w  = in_valid & in_ready;

`ifdef TT_LUT_SWEEP_EN
    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   ones_q, ones_d;

    assign in_ready = ~reset & (state_q == IDLE) & ~sweep_start & slot_w;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_idx_d   = out_idx_q;
        if (state_q == IDLE) begin
            if (sweep_start) begin
                state_d = SWEEP;
                idx_d   = '0;
                ones_d  = '0;
            end
            if (accept_w) begin
                out_valid_d = 1'b1;
                out_y_d     = table_w[in_data];
                out_idx_d   = in_data;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end else if (slot_w) begin
            // Each emitted index reads the live table, so a commit mid-sweep
            // applies from the next index onward.
            out_valid_d = 1'b1;
            out_y_d     = table_w[idx_q];
            out_idx_d   = idx_q;
            ones_d      = ones_q + {{N_IN{1'b0}}, table_w[idx_q]};
            idx_d       = idx_q + 1'b1;
            if (idx_q == '1) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
        end
    end

    assign sweep_busy = (state_q == SWEEP);
    assign ones_cnt   = ones_q;
`else
    assign in_ready = ~reset & slot_w;

    always_comb begin
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_idx_d   = out_idx_q;
        if (accept_w) begin
            out_valid_d = 1'b1;
            out_y_d     = table_w[in_data];
            out_idx_d   = in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_idx   = out_idx_q;

endmodule

`default_nettype wire

// File: doc/tt_lut_engine.md
TT_LUT_ENGINE -- requirements
Module: tt_lut_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, giving the number of truth-table inputs (range 1..6).
REQ-002 The block SHALL have parameter TT_RESET, width 2**N_IN, default 8'h12, giving the truth table after reset; bit k is y for input value k.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state rising-edge triggered.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit: serial table bit present.
REQ-006 The block SHALL have port cfg_bit, input, 1 bit: serial table data, index 0 first.
REQ-007 The block SHALL have port cfg_ready, output, 1 bit: loader accepts a bit, constant 1 outside reset.
REQ-008 The block SHALL have port cfg_done, output, 1 bit: one-cycle pulse when a full table commits.
REQ-009 The block SHALL have port in_valid, input, 1 bit: evaluation request.
REQ-010 The block SHALL have port in_data, input, N_IN bits: minterm index to evaluate.
REQ-011 The block SHALL have port in_ready, output, 1 bit: request accepted this cycle.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result held.
REQ-013 The block SHALL have port out_y, output, 1 bit: table value.
REQ-014 The block SHALL have port out_idx, output, N_IN bits: index that produced out_y.
REQ-015 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-016 The block SHALL have port sweep_start, input, 1 bit: begin auto-sweep (SWEEP_EN only).
REQ-017 The block SHALL have port sweep_busy, output, 1 bit: sweep in progress (SWEEP_EN only).
REQ-018 The block SHALL have port ones_cnt, output, N_IN+1 bits: count of y=1 results in the last sweep (SWEEP_EN only).

Function
REQ-019 Loader: each cycle with cfg_valid high SHALL shift cfg_bit into a shadow register and increment a bit counter.
REQ-020 When the 2**N_IN-th bit is accepted, the shadow SHALL copy atomically into the active table on that edge, cfg_done SHALL pulse the next cycle, and the counter SHALL wrap to 0.
REQ-021 Evaluation SHALL always use the active table; a load in progress SHALL NOT alter results.
REQ-022 A result using the new table SHALL be possible on the cycle after commit.
REQ-023 in_ready SHALL equal (state==IDLE) & ~sweep_start & (~out_valid | out_ready).
REQ-024 A handshake SHALL register out_y=table[in_data] and out_idx=in_data with latency 1 cycle.
REQ-025 out_valid SHALL stay high with out_y and out_idx stable until out_ready.
REQ-026 With out_valid and out_ready both high, a simultaneous new request SHALL be accepted, giving full throughput.
REQ-027 The FSM SHALL have states IDLE and SWEEP.
REQ-028 IDLE -> SWEEP SHALL occur on sweep_start in IDLE; sweep_start SHALL have priority over a same-cycle in_valid, which is not accepted.
REQ-029 On entry to SWEEP, ones_cnt SHALL clear to 0 and the index SHALL be 0.
REQ-030 SWEEP SHALL load index i into the output register whenever ~out_valid | out_ready, then increment i, adding out_y to ones_cnt.
REQ-031 SWEEP SHALL stall under backpressure without skipping or repeating an index.
REQ-032 After index 2**N_IN-1 is loaded, the FSM SHALL return to IDLE and ones_cnt SHALL hold until the next sweep.
REQ-033 sweep_start SHALL be ignored in SWEEP.
REQ-034 sweep_busy SHALL be high exactly in SWEEP.
REQ-035 A table commit during SWEEP SHALL take effect from the next index loaded.

Reset
REQ-036 Asserting reset SHALL immediately set the active and shadow tables to TT_RESET, the bit counter to 0, the state to IDLE, the index to 0, out_valid to 0, out_y to 0, out_idx to 0, cfg_done to 0, ones_cnt to 0, and sweep_busy to 0.
REQ-037 During reset, cfg_ready and in_ready SHALL be 0.
REQ-038 Reset mid-load SHALL discard the partial shadow; reset mid-sweep SHALL abort the sweep with no further outputs.

Configuration
REQ-039 With macro TT_LUT_SWEEP_EN defined, the SWEEP state, the sweep_start, sweep_busy, ones_cnt ports and the counters SHALL be present.
REQ-040 Without TT_LUT_SWEEP_EN, those ports SHALL be absent, the FSM SHALL be IDLE-only, and in_ready SHALL be ~out_valid | out_ready; loader and evaluation behaviour SHALL be unchanged.

Structure
REQ-041 Package tt_lut_pkg SHALL hold the state enum (IDLE, SWEEP), TT_RESET_DEFAULT = 8'h12, and N_IN_MAX = 6.
REQ-042 One sub-module, tt_lut_loader, SHALL contain the shadow register, bit counter, commit and cfg_done logic.

Verification
REQ-043 After reset with defaults and out_ready=1, requests for in_data 0..7 SHALL return out_y = 0,1,0,0,1,0,0,0, each one cycle after acceptance.
REQ-044 Serially loading 8'hA5, index 0 first, SHALL pulse cfg_done once; in_data=2 SHALL then give out_y=1 and in_data=1 SHALL give out_y=0.
REQ-045 Holding out_ready=0 for 5 cycles with a result pending SHALL keep out_y, out_idx, and out_valid=1 stable, keep in_ready=0, and produce no lost or duplicated results.
REQ-046 A default-table sweep with out_ready toggling every cycle SHALL emit out_idx 0..7 in order, end with ones_cnt=2, and drop sweep_busy after index 7.
REQ-047 Same-cycle sweep_start and in_valid in IDLE SHALL start the sweep and leave in_ready=0.
REQ-048 Reset after 4 of 8 cfg bits and mid-sweep SHALL restore the TT_RESET table, set out_valid=0, and make a subsequent full load commit normally.
